// File: rtl/decode_hazard_if.sv
// Decode-stage hazard bundle: decode slot description in, stall and forwarding selects out.
// The master drives the decode instruction; the slave is the hazard controller.
interface decode_hazard_if #(
    parameter int SIZE  = 32,
    parameter int CNT_W = 32
);
    localparam int BITS = (SIZE > 1) ? $clog2(SIZE) : 1;

    logic            id_valid;
    logic [BITS-1:0] id_rs;
    logic [BITS-1:0] id_rt;
    logic            id_use_rs;
    logic            id_use_rt;
    logic [BITS-1:0] id_dest;
    logic            id_wr;
    logic            id_load;
    logic            flush;
    logic            stall;
    logic [1:0]      fwd_a;
    logic [1:0]      fwd_b;
    logic [CNT_W-1:0] stall_count;

    modport master (
        output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_dest, id_wr, id_load, flush,
        input  stall, fwd_a, fwd_b, stall_count
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_dest, id_wr, id_load, flush,
        output stall, fwd_a, fwd_b, stall_count
    );
endinterface

// File: rtl/decode_hazard_ctrl.sv
// Decode hazard scheduler: tracks EX/MEM destinations, stalls on load-use, issues forward selects.
// `define FWD_STALL_EN removes forwarding and stalls on any RAW against EX or MEM instead.
module decode_hazard_ctrl #(
    parameter int SIZE  = 32,
    parameter int CNT_W = 32
) (
    input  logic           clk,
    input  logic           reset,
    decode_hazard_if.slave hz
);
    localparam int BITS = (SIZE > 1) ? $clog2(SIZE) : 1;

    logic            ex_v, ex_wr, ex_load;
    logic [BITS-1:0] ex_dest;
    logic            mem_v, mem_wr;
    logic [BITS-1:0] mem_dest;
    logic            ex_hit_a, ex_hit_b, mem_hit_a, mem_hit_b;
    logic            bubble;

    function automatic logic slot_match(input logic v, input logic wr, input logic [BITS-1:0] dest,
                                        input logic [BITS-1:0] r, input logic use_r);
        return v && wr && (dest == r) && (r != '0) && use_r;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    always_comb begin
        ex_hit_a  = slot_match(ex_v,  ex_wr,  ex_dest,  hz.id_rs, hz.id_use_rs);
        ex_hit_b  = slot_match(ex_v,  ex_wr,  ex_dest,  hz.id_rt, hz.id_use_rt);
        mem_hit_a = slot_match(mem_v, mem_wr, mem_dest, hz.id_rs, hz.id_use_rs);
        mem_hit_b = slot_match(mem_v, mem_wr, mem_dest, hz.id_rt, hz.id_use_rt);
`ifdef FWD_STALL_EN
        hz.stall  = hz.id_valid && !hz.flush && (ex_hit_a || ex_hit_b || mem_hit_a || mem_hit_b);
`else
        hz.stall  = hz.id_valid && !hz.flush && ex_load && (ex_hit_a || ex_hit_b);
`endif
        bubble    = hz.stall || hz.flush || !hz.id_valid;
    end

    // ID -> EX -> MEM slot control; EX and MEM always advance, a stall only injects a bubble
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_v           <= 1'b0;
            mem_v          <= 1'b0;
            hz.stall_count <= '0;
        end else begin
            ex_v  <= !bubble;
            mem_v <= ex_v;
            if (hz.stall)
                hz.stall_count <= sat_inc(hz.stall_count);
        end
    end

    // Slot payload is qualified by the valid bits, so it carries no reset
    always_ff @(posedge clk) begin
        ex_dest  <= hz.id_dest;
        ex_wr    <= hz.id_wr;
        ex_load  <= hz.id_load;
        mem_dest <= ex_dest;
        mem_wr   <= ex_wr;
    end

`ifdef FWD_STALL_EN
    assign hz.fwd_a = 2'b00;
    assign hz.fwd_b = 2'b00;
`else
    // EX-stage operand selects; the EX slot is the youngest producer and wins over MEM
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hz.fwd_a <= 2'b00;
            hz.fwd_b <= 2'b00;
        end else begin
            hz.fwd_a <= bubble ? 2'b00 : ex_hit_a ? 2'b01 : mem_hit_a ? 2'b10 : 2'b00;
            hz.fwd_b <= bubble ? 2'b00 : ex_hit_b ? 2'b01 : mem_hit_b ? 2'b10 : 2'b00;
        end
    end
`endif
endmodule
